seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
- Parametrised Moore serial pattern detector; successor to the fixed 3-bit flip-flop machine.
- Samples one serial bit per clock and tracks the longest matched prefix of a compile-time pattern of length N.
- Raises F while a full match is held and counts matches with a saturating counter.
- Supports overlapping and non-overlapping detection modes; sits on a serial input path as a self-contained control block.

Parameters:
- N, 4, pattern length in bits (2..16).
- PATTERN, 4'b1011, N-bit pattern; PATTERN[N-1] is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = after a match, restart from empty.
- CW, 4, width of match counter COUNT.
- SW, $clog2(N+1), width of state output S.

Ports:
- CLK  input  1  clock; all state changes occur on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- x  input  1  serial data bit, sampled on the rising CLK edge.
- EN  input  1  sample enable; when 0, state and COUNT hold.
- CLR  input  1  synchronous clear of COUNT only.
- F  output  1  match flag (Moore): 1 iff S == N.
- S  output  SW  current state = number of pattern bits currently matched (0..N).
- COUNT  output  CW  number of matches since reset/clear, saturating.

Behaviour:
- Reset: RESET=1 forces S=0, F=0, COUNT=0 immediately, without waiting for a clock edge, and holds them while asserted. The first sample is taken at the first rising edge after RESET falls.
- State k means the last k sampled bits equal the first k pattern bits, and k is maximal.
- Next state on a rising edge with EN=1:
  - From state k<N, append x to the matched prefix. The next state is the length of the longest pattern prefix that is a suffix of that string (KMP failure function).
  - Failure transitions are computed at elaboration, via a function or generate loop, for any N/PATTERN. No hand-coded table.
- From state N:
  - OVERLAP=1: apply the same rule as any other state, treating the matched prefix as the whole pattern.
  - OVERLAP=0: transition as from state 0 (x==PATTERN[N-1] gives 1, else 0).
- F is decoded combinationally from registered S only; it never depends on the current x.
- Latency: F rises in the cycle after the edge that samples the final pattern bit. It stays high for exactly one cycle unless the next transition returns to N (possible only with OVERLAP=1 and a periodic pattern, e.g. 1111).
- COUNT update on a rising edge:
  - CLR=1: COUNT <= 0. CLR has priority over increment, and applies regardless of EN.
  - Otherwise, if EN=1 and next state == N: COUNT <= COUNT+1, saturating at 2^CW-1 (no wrap).
  - A hold in state N via the overlap self-loop counts each cycle.
- EN=0: S and COUNT are unchanged (CLR still acts on COUNT); the bit on x is discarded.
- S never exceeds N; unused encodings (N < 2^SW-1) are unreachable. If reached, they must go to 0 on the next enabled edge.
- Reset mid-match: the partial match is lost; detection restarts from S=0.
- No combinational path from x, EN or CLR to any output.

Test Plan:
- Reset: RESET=1 mid-stream while S=3 -> S=0, F=0, COUNT=0 before the next clock edge; a full pattern afterwards is detected normally.
- Failure function (N=4, PATTERN=1011, OVERLAP=1): bits 1,1,0,1,1 -> S sequence 1,1,2,3,4. F=1 for one cycle after the 5th edge; COUNT=1.
- Overlap (OVERLAP=1): bits 1,0,1,1,0,1,1 -> S = 1,2,3,4,2,3,4. F pulses after bits 4 and 7; COUNT=2.
- Non-overlap (OVERLAP=0), same stream -> S = 1,2,3,4,0,1,1. Single F pulse; COUNT=1.
- Enable/clear: pattern fed with EN=0 inserted between bits 2 and 3 for 3 cycles -> S holds at 2, then the match completes and COUNT increments. CLR=1 on the same edge as a match -> COUNT=0, F=1.
- Saturation (CW=2, PATTERN=1111, OVERLAP=1): 10 consecutive 1s -> S stays 4 from bit 4 onward, F held high, and COUNT stops at 3.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Parametrised Moore serial pattern detector. One bit of x is sampled per
//   enabled rising edge of CLK. S tracks the longest prefix of PATTERN that
//   is also a suffix of the sampled stream. F flags a complete match, and
//   COUNT counts matches with saturation.
//
//   Ports
//     CLK    in   1   clock, rising edge
//     RESET  in   1   asynchronous active-high reset
//     x      in   1   serial data bit
//     EN     in   1   sample enable (0: S, F, COUNT hold; x discarded)
//     CLR    in   1   synchronous clear of COUNT, independent of EN
//     F      out  1   1 iff S == N
//     S      out  SW  number of pattern bits currently matched
//     COUNT  out  CW  saturating match counter
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   0          | no pattern bits matched
//   k (1..N-1) | last k bits equal PATTERN[N-1 -: k]
//   N          | full match, F high
//   > N        | unreachable encoding; falls to 0 on the next enabled edge
module seq_detector_param #(
   parameter int             N       = 4,
   parameter logic [N-1:0]   PATTERN = 4'b1011,
   parameter bit             OVERLAP = 1'b1,
   parameter int             CW      = 4,
   parameter int             SW      = $clog2(N + 1)
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          x,
   input  logic          EN,
   input  logic          CLR,
   output logic          F,
   output logic [SW-1:0] S,
   output logic [CW-1:0] COUNT
);

   localparam logic [SW-1:0] S_FULL = SW'(N);

   // Pattern bit at position q, where position 0 is the first bit received.
   function automatic int pat_bit(input int q);
      logic [N-1:0] pv;
      pv = PATTERN >> (N - 1 - q);
      return pv[0] ? 1 : 0;
   endfunction

   // Elaboration-time KMP transition. The string considered is the first
   // k pattern bits followed by b. The result is the length of the longest
   // pattern prefix that is a suffix of that string.
   function automatic int delta(input int k, input int b);
      int best;
      int len;
      int ok;
      int q;
      int c;
      best = 0;
      len  = k + 1;
      for (int l = 1; l <= N; l++) begin
         if (l <= len) begin
            ok = 1;
            for (int j = 0; j < l; j++) begin
               q = len - l + j;
               c = (q < k) ? pat_bit(q) : b;
               if (c != pat_bit(j)) ok = 0;
            end
            if (ok == 1) best = l;
         end
      end
      return best;
   endfunction

   // Next-state table for every encoding of S, indexed by the current state.
   logic [SW-1:0] nxt0 [2**SW];
   logic [SW-1:0] nxt1 [2**SW];

   for (genvar k = 0; k < 2**SW; k++) begin : g_next
      if (k > N) begin : g_unused
         assign nxt0[k] = '0;
         assign nxt1[k] = '0;
      end else begin : g_used
         // Without overlap a full match restarts from the empty prefix.
         localparam int FROM = (k == N && !OVERLAP) ? 0 : k;
         localparam int D0   = delta(FROM, 0);
         localparam int D1   = delta(FROM, 1);
         assign nxt0[k] = D0[SW-1:0];
         assign nxt1[k] = D1[SW-1:0];
      end
   end

   logic [SW-1:0] s_next;

   always_comb begin
      s_next = x ? nxt1[S] : nxt0[S];
   end

   // F is registered alongside S, so it always equals (S == N) without
   // depending on the current x.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         S     <= '0;
         F     <= 1'b0;
         COUNT <= '0;
      end else begin
         if (EN) begin
            S <= s_next;
            F <= (s_next == S_FULL);
         end
         if (CLR) begin
            COUNT <= '0;
         end else if (EN && (s_next == S_FULL) && (COUNT != '1)) begin
            COUNT <= COUNT + CW'(1);
         end
      end
   end

endmodule
